// File: rtl/memctrl_responder.sv
// Block-RAM stand-in for the SDRAM MemoryController user port.
// Deterministic LATENCY-cycle busy window per access, optional clear-on-reset.
module memctrl_responder #(
   parameter int ADDR_W     = 14,
   parameter int LATENCY    = 4,
   parameter int INIT_CLEAR = 1
) (
   input  logic        clk,
   input  logic        rst_x,
   input  logic        read_a,
   input  logic        read_b,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   input  logic [3:0]  mask,
   output logic [31:0] dout_a,
   output logic [31:0] dout_b,
   output logic        busy,
   output logic        mem_initialized,
   output logic [31:0] total_written
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_ACCESS
   } state_t;

   typedef enum logic [1:0] {
      OP_WR,
      OP_RA,
      OP_RB
   } op_t;

   logic [31:0]       mem_q [DEPTH];
   state_t            state_q;
   op_t               op_q;
   logic [ADDR_W-1:0] icnt_q;
   logic [7:0]        acnt_q;
   logic [31:0]       hold_q;
   logic [31:0]       dout_a_q;
   logic [31:0]       dout_b_q;
   logic              busy_q;
   logic              init_q;
   logic [31:0]       tw_q;

   logic [ADDR_W-1:0] widx;
   logic              we_d;
   logic [ADDR_W-1:0] widx_d;
   logic [31:0]       wdata_d;
   logic [3:0]        be_d;
   logic              unused_addr_bits;

   assign widx = addr[ADDR_W+1:2];
   assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

   // Array write port: clearing in INIT, or a write accepted in IDLE.
   always_comb begin
      we_d    = 1'b0;
      widx_d  = widx;
      wdata_d = din;
      be_d    = ~mask;
      if (rst_x) begin
         if (state_q == S_INIT && INIT_CLEAR != 0) begin
            we_d    = 1'b1;
            widx_d  = icnt_q;
            wdata_d = '0;
            be_d    = 4'hF;
         end else if (state_q == S_IDLE && write) begin
            we_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we_d) begin
         for (int i = 0; i < 4; i++) begin
            if (be_d[i]) mem_q[widx_d][8*i +: 8] <= wdata_d[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_x) begin
         state_q  <= S_INIT;
         icnt_q   <= '0;
         acnt_q   <= '0;
         busy_q   <= 1'b1;
         init_q   <= 1'b0;
         dout_a_q <= '0;
         dout_b_q <= '0;
         tw_q     <= '0;
      end else begin
         unique case (state_q)
            S_INIT: begin
               if (INIT_CLEAR == 0 || icnt_q == '1) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  init_q  <= 1'b1;
               end else begin
                  icnt_q <= icnt_q + 1'b1;
               end
            end
            S_IDLE: begin
               if (write || read_a || read_b) begin
                  state_q <= S_ACCESS;
                  acnt_q  <= LAT_M1;
                  busy_q  <= 1'b1;
               end
               if (write) begin
                  op_q <= OP_WR;
                  tw_q <= tw_q + 32'd1;
               end else if (read_a) begin
                  op_q   <= OP_RA;
                  hold_q <= mem_q[widx];
               end else if (read_b) begin
                  op_q   <= OP_RB;
                  hold_q <= mem_q[widx];
               end
            end
            S_ACCESS: begin
               if (acnt_q == 8'd0) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  if (op_q == OP_RA) dout_a_q <= hold_q;
                  if (op_q == OP_RB) dout_b_q <= hold_q;
               end else begin
                  acnt_q <= acnt_q - 8'd1;
               end
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

   assign dout_a          = dout_a_q;
   assign dout_b          = dout_b_q;
   assign busy            = busy_q;
   assign mem_initialized = init_q;
   assign total_written   = tw_q;

endmodule

// File: tb/tb_memctrl_responder.sv
// Scoreboard bench for memctrl_responder: ADDR_W=4, LATENCY=4, INIT_CLEAR=1.
// Stimulus queues expectations; a negedge monitor checks each busy fall.
module tb_memctrl_responder;

   localparam int ADDR_W = 4;
   localparam int LAT    = 4;
   localparam int INIT_CYC = 1 << ADDR_W;

   logic        clk = 1'b0;
   logic        rst_x;
   logic        read_a, read_b, write;
   logic [31:0] addr, din;
   logic [3:0]  mask;
   logic [31:0] dout_a, dout_b, total_written;
   logic        busy, mem_initialized;

   memctrl_responder #(
      .ADDR_W(ADDR_W),
      .LATENCY(LAT),
      .INIT_CLEAR(1)
   ) dut (
      .clk(clk),
      .rst_x(rst_x),
      .read_a(read_a),
      .read_b(read_b),
      .write(write),
      .addr(addr),
      .din(din),
      .mask(mask),
      .dout_a(dout_a),
      .dout_b(dout_b),
      .busy(busy),
      .mem_initialized(mem_initialized),
      .total_written(total_written)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] tw;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_pass = 0;
   logic [31:0] exp_a, exp_b, exp_tw;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // Monitor: every busy fall must match the oldest queued expectation.
   int   bcnt = 0;
   logic was_busy = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (busy === 1'b1) begin
         if (rst_x === 1'b1) bcnt++;
         else bcnt = 0;
      end else if (busy === 1'b0 && was_busy) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: busy fell, no entry queued");
         end else begin
            e = sb.pop_front();
            chk("dout_a", dout_a, e.a);
            chk("dout_b", dout_b, e.b);
            chk("total_written", total_written, e.tw);
            chk("mem_initialized", {31'b0, mem_initialized}, 32'd1);
            chk("busy_cycles", 32'(bcnt), 32'(e.lat));
         end
         bcnt = 0;
      end
      was_busy = (busy === 1'b1);
   end

   task automatic push(input int lat);
      exp_t e;
      e.a = exp_a;
      e.b = exp_b;
      e.tw = exp_tw;
      e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         $display("FAIL idle_timeout: busy=%b, expected 0", busy);
      end
   endtask

   task automatic op(input logic w, input logic ra, input logic rb,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m);
      wait_idle();
      write  = w;
      read_a = ra;
      read_b = rb;
      addr   = a;
      din    = d;
      mask   = m;
      push(LAT);
      @(posedge clk);
      #1;
      write  = 1'b0;
      read_a = 1'b0;
      read_b = 1'b0;
   endtask

   task automatic reset_checks();
      chk("rst_busy", {31'b0, busy}, 32'd1);
      chk("rst_init", {31'b0, mem_initialized}, 32'd0);
      chk("rst_dout_a", dout_a, 32'd0);
      chk("rst_total", total_written, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_x = 1'b0;
      read_a = 1'b0;
      read_b = 1'b0;
      write = 1'b0;
      addr = '0;
      din = '0;
      mask = 4'hF;
      exp_a = 0;
      exp_b = 0;
      exp_tw = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_checks();
      push(INIT_CYC);
      rst_x = 1'b1;

      op(0, 1, 0, 32'h14, 0, 4'hF);
      exp_tw = 1;
      op(1, 0, 0, 32'h10, 32'hDEADBEEF, 4'b0000);
      exp_a = 32'hDEADBEEF;
      op(0, 1, 0, 32'h10, 0, 4'hF);
      exp_tw = 2;
      op(1, 0, 0, 32'h10, 32'h11223344, 4'b1010);
      exp_b = 32'hDE22BE44;
      op(0, 0, 1, 32'h10, 0, 4'hF);
      exp_tw = 3;
      op(1, 0, 0, 32'h10, 32'h0, 4'b1111);
      exp_a = 32'hDE22BE44;
      op(0, 1, 0, 32'h10, 0, 4'hF);
      exp_tw = 4;
      op(1, 1, 0, 32'h20, 32'h55AA55AA, 4'b0000);
      exp_b = 32'h55AA55AA;
      op(0, 0, 1, 32'h20, 0, 4'hF);
      exp_tw = 5;
      op(1, 0, 0, 32'h03, 32'hCAFEF00D, 4'b0000);
      exp_a = 32'hCAFEF00D;
      op(0, 1, 0, 32'h00, 0, 4'hF);
      exp_b = 32'hCAFEF00D;
      op(0, 0, 1, 32'h40, 0, 4'hF);

      // Read that never completes: reset lands in its second busy cycle.
      wait_idle();
      read_a = 1'b1;
      addr = 32'h20;
      @(posedge clk);
      #1;
      read_a = 1'b0;
      @(posedge clk);
      #1;
      rst_x = 1'b0;
      @(posedge clk);
      #1;
      reset_checks();
      chk("rst_dout_b", dout_b, 32'd0);
      exp_a = 0;
      exp_b = 0;
      exp_tw = 0;
      push(INIT_CYC);
      rst_x = 1'b1;

      op(0, 1, 0, 32'h20, 0, 4'hF);
      exp_tw = 1;
      op(1, 0, 0, 32'h24, 32'h12345678, 4'b0000);
      exp_a = 32'h12345678;
      op(0, 1, 0, 32'h24, 0, 4'hF);

      wait_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
